// File: rtl/shift_register_universal.sv
// ---------------------------------------------------------------------------
// shift_register_universal
//
// Parametrised universal shift register. Supports hold, shift right, shift
// left and parallel load. Rotation is optional for both shift directions.
// A saturating fill counter tracks how many serial bits have entered since
// the last load or reset.
//
// Parameters
//   WIDTH     register width in bits (>= 2)
//   CW        width of cnt, derived from WIDTH; do not override
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   en        cycle enable; 0 holds all state
//   mode      00 hold, 01 shift right, 10 shift left, 11 parallel load
//   rot       1 = rotate instead of serial fill (modes 01/10)
//   sin_msb   serial input entering bit WIDTH-1 on a right shift
//   sin_lsb   serial input entering bit 0 on a left shift
//   D         parallel load data
//   Q         register contents
//   Qbar      bitwise complement of Q
//   sout_lsb  Q[0], the bit leaving on a right shift
//   sout_msb  Q[WIDTH-1], the bit leaving on a left shift
//   cnt       serial bits filled since load/reset, saturating at WIDTH
//   full      cnt == WIDTH
// ---------------------------------------------------------------------------
module shift_register_universal #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             rot,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic [CW-1:0]    cnt,
    output logic             full
);

    localparam logic [1:0]    MODE_HOLD  = 2'b00;
    localparam logic [1:0]    MODE_RIGHT = 2'b01;
    localparam logic [1:0]    MODE_LEFT  = 2'b10;
    localparam logic [1:0]    MODE_LOAD  = 2'b11;
    localparam logic [CW-1:0] CNT_MAX    = CW'(WIDTH);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    // Candidate next values for each shift flavour
    logic [WIDTH-1:0] shr_fill;
    logic [WIDTH-1:0] shr_rot;
    logic [WIDTH-1:0] shl_fill;
    logic [WIDTH-1:0] shl_rot;
    logic [CW-1:0]    cnt_inc;
    logic             cnt_at_max;

    assign shr_fill = {sin_msb,       q_q[WIDTH-1:1]};
    assign shr_rot  = {q_q[0],        q_q[WIDTH-1:1]};
    assign shl_fill = {q_q[WIDTH-2:0], sin_lsb};
    assign shl_rot  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};

    // Fill counter saturates at WIDTH rather than wrapping
    assign cnt_at_max = (cnt_q == CNT_MAX);
    assign cnt_inc    = cnt_at_max ? cnt_q : (cnt_q + CW'(1));

    // Next-state selection; only serial-fill shifts advance the counter
    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (en) begin
            case (mode)
                MODE_HOLD: begin
                    q_d   = q_q;
                    cnt_d = cnt_q;
                end
                MODE_RIGHT: begin
                    if (rot) begin
                        q_d = shr_rot;
                    end else begin
                        q_d   = shr_fill;
                        cnt_d = cnt_inc;
                    end
                end
                MODE_LEFT: begin
                    if (rot) begin
                        q_d = shl_rot;
                    end else begin
                        q_d   = shl_fill;
                        cnt_d = cnt_inc;
                    end
                end
                MODE_LOAD: begin
                    q_d   = D;
                    cnt_d = '0;
                end
                default: begin
                    q_d   = q_q;
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    // Outputs derive from registered state only; no input-to-output path
    assign Q        = q_q;
    assign Qbar     = ~q_q;
    assign sout_lsb = q_q[0];
    assign sout_msb = q_q[WIDTH-1];
    assign cnt      = cnt_q;
    assign full     = cnt_at_max;

endmodule
